modexp_sequencer: RTL and testbench
===================================

// Module: modexp_sequencer
// PURPOSE
//  Sequences one shared modular-multiplier instance to compute result = base^exponent mod modulus.
//  Uses left-to-right binary square-and-multiply.
//  Sits between the RSA top-level control (start/done) and the bit-serial interleaved modmul unit.
//  The modmul unit takes operands a, b, n and returns (a*b) mod n after a variable latency.
//  This block owns all operand muxing and step counting for that unit.
// PARAMETERS
//  WIDTH      6    operand / modulus / result width in bits
//  EXP_WIDTH  6    exponent width in bits; number of square steps per operation
//  TIMEOUT    64   max cycles to wait for mm_done per multiplier call before aborting
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          synchronous, active-high reset
//  start      in   1          request; accepted only in IDLE
//  base       in   WIDTH      message/base; must be < modulus (caller guarantees)
//  exponent   in   EXP_WIDTH  exponent e
//  modulus    in   WIDTH      modulus n
//  busy       out  1          high from the cycle after start is accepted until done
//  done       out  1          one-cycle pulse when result is valid
//  err        out  1          valid with done; 1 = modulus==0 or multiplier timeout
//  result     out  WIDTH      base^e mod n; held until the next accepted start
//  mm_start   out  1          one-cycle pulse; multiplier latches mm_a/mm_b/mm_n on this cycle
//  mm_a       out  WIDTH      multiplier operand a
//  mm_b       out  WIDTH      multiplier operand b
//  mm_n       out  WIDTH      multiplier modulus
//  mm_done    in   1          multiplier completion; may be a level or a pulse; sampled only in *_WAIT
//  mm_result  in   WIDTH      (mm_a*mm_b) mod mm_n; valid when mm_done=1
// BEHAVIOUR
//  Reset values
//  - All outputs 0; state IDLE; internal r=0, bit index=0, timeout counter=0.
//  - Reset mid-operation aborts immediately.
//  - No done pulse follows an abort; the multiplier is left to finish (its result is ignored).
//  Start and latching
//  - start in IDLE latches base, exponent, modulus into internal registers.
//  - Inputs may change afterwards without effect.
//  - start outside IDLE is ignored.
//  Trivial cases (decided in LOAD, the cycle after start)
//  - modulus==0: go to DONE with result=0, err=1.
//  - modulus==1: go to DONE with result=0, err=0.
//  - Otherwise r=1 and idx=EXP_WIDTH-1.
//  FSM: IDLE -> LOAD -> SQ_ISSUE -> SQ_WAIT -> [MUL_ISSUE -> MUL_WAIT] -> NEXT -> ... -> DONE -> IDLE
//  - SQ_ISSUE: mm_a=r, mm_b=r, mm_n=n_reg, mm_start=1 for exactly one cycle.
//  - SQ_WAIT: hold mm_a/mm_b/mm_n stable.
//    - On mm_done: r<=mm_result.
//    - If e[idx]==1 go to MUL_ISSUE, else go to NEXT.
//  - MUL_ISSUE: mm_a=r, mm_b=base_reg, mm_start=1. MUL_WAIT: on mm_done, r<=mm_result, then NEXT.
//  - NEXT:
//    - If idx==0 go to DONE.
//    - Else idx<=idx-1 and go to SQ_ISSUE.
//    - idx decrement never wraps.
//  - DONE: result<=r, done=1 for one cycle, busy<=0, return to IDLE.
//  - Squares are issued for every exponent bit, including leading zeros.
//    - Call count = EXP_WIDTH + popcount(e); fully deterministic.
//    - e==0 therefore yields result 1.
//  Timeout
//  - The counter clears on each mm_start and increments every cycle in a WAIT state.
//  - If it reaches TIMEOUT without mm_done: go to DONE with err=1 and result=r at that point.
//  - mm_done arriving in the same cycle the count reaches TIMEOUT wins (no error).
//  Other rules
//  - mm_done seen in any state other than *_WAIT is ignored.
//  - Back-to-back operation: start may be asserted in the cycle after done and is accepted.
//  - All arithmetic is performed by the multiplier; this block only muxes operands and has no adders on the data path.
// TESTING
//  - base=3, e=5, n=7, behavioural modmul (latency 8)
//    -> result=5, err=0; exactly 8 mm_start pulses (6 squares + 2 multiplies).
//  - base=5, e=63, n=61 -> result=3 after 12 mm_start pulses.
//  - base=4, e=0, n=11 -> result=1; n=1 -> result=0, err=0; n=0 -> err=1 and done 2 cycles after start.
//  - Multiplier model never asserts mm_done -> done with err=1 exactly TIMEOUT cycles after the first mm_start.
//  - reset asserted during SQ_WAIT of the 3rd call -> all outputs 0 next cycle, no done.
//    Then base=2, e=10, n=13 -> result=10.
//  - start held high continuously for 3 operations -> start ignored while busy.
//    - Each op starts the cycle after done.
//    - mm_a/mm_b are stable across every WAIT; randomized multiplier latency 1..40 gives identical results.

Source files
------------

// File: rtl/modexp_sequencer.sv
// modexp_sequencer: drives one shared modular multiplier through left-to-right
// binary square-and-multiply to form base^exponent mod modulus.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start; operands latched on acceptance
// LOAD      | trivial-modulus decision, r=1, idx=top bit
// SQ_ISSUE  | mm_start pulse for r*r
// SQ_WAIT   | waiting for square result, operands held
// MUL_ISSUE | mm_start pulse for r*base
// MUL_WAIT  | waiting for multiply result, operands held
// NEXT      | step to the next exponent bit or finish
// DONE      | done pulse, result/err presented
//
// Multiplier operands are registered on entry to an ISSUE state, so they are
// stable from the mm_start cycle through the whole matching WAIT state.
// The wait timer counts cycles since mm_start; the abort decision is made in
// the last WAIT cycle so DONE lands exactly TIMEOUT cycles after mm_start,
// and an mm_done seen in that same last cycle still takes priority.

module modexp_sequencer #(
  parameter int WIDTH     = 6,
  parameter int EXP_WIDTH = 6,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_n,
  input  logic                 mm_done,
  input  logic [WIDTH-1:0]     mm_result
);

  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDX_TOP = IW'(EXP_WIDTH - 1);
  localparam logic [TW-1:0] TMO     = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SQ_ISSUE,
    S_SQ_WAIT,
    S_MUL_ISSUE,
    S_MUL_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 mm_start_q, mm_start_d;
  logic [WIDTH-1:0]     mm_a_q, mm_a_d;
  logic [WIDTH-1:0]     mm_b_q, mm_b_d;
  logic [WIDTH-1:0]     mm_n_q, mm_n_d;

  logic [TW-1:0] tmr_inc;
  logic          tmr_expire;

  assign tmr_inc    = tmr_q + TMR_ONE;
  assign tmr_expire = (tmr_inc == TMO);

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    exp_d      = exp_q;
    n_d        = n_q;
    r_d        = r_q;
    idx_d      = idx_q;
    tmr_d      = tmr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    result_d   = result_q;
    mm_start_d = 1'b0;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    mm_n_d     = mm_n_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base;
          exp_d   = exponent;
          n_d     = modulus;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (n_q == '0 || n_q == WIDTH'(1)) begin
          result_d = '0;
          err_d    = (n_q == '0);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end else begin
          r_d        = WIDTH'(1);
          idx_d      = IDX_TOP;
          mm_a_d     = WIDTH'(1);
          mm_b_d     = WIDTH'(1);
          mm_n_d     = n_q;
          mm_start_d = 1'b1;
          tmr_d      = '0;
          state_d    = S_SQ_ISSUE;
        end
      end

      S_SQ_ISSUE: begin
        tmr_d   = tmr_inc;
        state_d = S_SQ_WAIT;
      end

      S_SQ_WAIT: begin
        if (mm_done) begin
          r_d = mm_result;
          if (exp_q[idx_q]) begin
            mm_a_d     = mm_result;
            mm_b_d     = base_q;
            mm_start_d = 1'b1;
            tmr_d      = '0;
            state_d    = S_MUL_ISSUE;
          end else begin
            state_d = S_NEXT;
          end
        end else if (tmr_expire) begin
          result_d = r_q;
          err_d    = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end else begin
          tmr_d = tmr_inc;
        end
      end

      S_MUL_ISSUE: begin
        tmr_d   = tmr_inc;
        state_d = S_MUL_WAIT;
      end

      S_MUL_WAIT: begin
        if (mm_done) begin
          r_d     = mm_result;
          state_d = S_NEXT;
        end else if (tmr_expire) begin
          result_d = r_q;
          err_d    = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end else begin
          tmr_d = tmr_inc;
        end
      end

      S_NEXT: begin
        if (idx_q == '0) begin
          result_d = r_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end else begin
          idx_d      = idx_q - IW'(1);
          mm_a_d     = r_q;
          mm_b_d     = r_q;
          mm_start_d = 1'b1;
          tmr_d      = '0;
          state_d    = S_SQ_ISSUE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      exp_q      <= '0;
      n_q        <= '0;
      r_q        <= '0;
      idx_q      <= '0;
      tmr_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
      mm_start_q <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_n_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      n_q        <= n_d;
      r_q        <= r_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      result_q   <= result_d;
      mm_start_q <= mm_start_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      mm_n_q     <= mm_n_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign result   = result_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_n     = mm_n_q;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Bench for modexp_sequencer: behavioural modmul responder, reference modexp
// model feeding a scoreboard queue, and a done-triggered monitor.

module tb_modexp_sequencer;

  localparam int W   = 6;
  localparam int EW  = 6;
  localparam int TMO = 64;

  typedef struct packed {
    logic [W-1:0] res;
    logic         err;
    logic [7:0]   calls;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [W-1:0]  base, modulus;
  logic [EW-1:0] exponent;
  logic          busy, done, err, mm_start, mm_done;
  logic [W-1:0]  result, mm_a, mm_b, mm_n, mm_result;

  modexp_sequencer #(.WIDTH(W), .EXP_WIDTH(EW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base),
    .exponent(exponent), .modulus(modulus), .busy(busy), .done(done),
    .err(err), .result(result), .mm_start(mm_start), .mm_a(mm_a),
    .mm_b(mm_b), .mm_n(mm_n), .mm_done(mm_done), .mm_result(mm_result)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Reference: plain square-and-multiply over every exponent bit.
  function automatic exp_t ref_op(input logic [W-1:0] b, input logic [EW-1:0] e,
                                  input logic [W-1:0] n);
    exp_t x;
    int   r, calls, nn;
    x = '0;
    nn = int'(n);
    if (nn == 0) begin
      x.err = 1'b1;
      return x;
    end
    if (nn == 1) return x;
    r = 1;
    calls = 0;
    for (int i = EW - 1; i >= 0; i--) begin
      r = (r * r) % nn;
      calls++;
      if (e[i]) begin
        r = (r * int'(b)) % nn;
        calls++;
      end
    end
    x.res = W'(r);
    x.calls = 8'(calls);
    return x;
  endfunction

  // Behavioural multiplier: latency lat_mode (>0), random 1..40 (0), never (<0).
  int lat_mode = 8;
  int mcnt = 0;
  logic [W-1:0] ma = '0, mb = '0, mn = '0;
  initial begin
    mm_done = 1'b0;
    mm_result = '0;
    forever begin
      @(negedge clk);
      if (mm_start) begin
        ma = mm_a; mb = mm_b; mn = mm_n;
        mm_done = 1'b0;
        if (lat_mode < 0) mcnt = -1;
        else if (lat_mode == 0) mcnt = int'($urandom_range(1, 40));
        else mcnt = lat_mode;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          mm_done = 1'b1;
          mm_result = (mn == '0) ? '0 : W'((32'(ma) * 32'(mb)) % 32'(mn));
        end
      end
    end
  end

  // Monitor: counts calls, checks operand stability, pops scoreboard on done.
  exp_t sbq[$];
  exp_t mon_e;
  int ncalls = 0, stab_bad = 0, done_cnt = 0, done_cyc = 0;
  int first_start = -1, last_first_start = -1;
  logic [W-1:0] la = '0, lb = '0, ln = '0;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      ncalls = 0; stab_bad = 0; first_start = -1;
      la = '0; lb = '0; ln = '0;
    end else begin
      if (mm_start) begin
        la = mm_a; lb = mm_b; ln = mm_n;
        if (ncalls == 0) first_start = cyc;
        ncalls++;
      end else if (busy && (mm_a != la || mm_b != lb || mm_n != ln)) begin
        stab_bad++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        last_first_start = first_start;
        if (sbq.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("result", int'(result), int'(mon_e.res));
          chk("err", int'(err), int'(mon_e.err));
          chk("call_count", ncalls, int'(mon_e.calls));
          chk("operand_stable", stab_bad, 0);
        end
        ncalls = 0; stab_bad = 0; first_start = -1;
      end
    end
  end

  int start_cyc = 0;

  task automatic issue(input logic [W-1:0] b, input logic [EW-1:0] e,
                       input logic [W-1:0] n, input exp_t ex);
    @(negedge clk); #1;
    base = b; exponent = e; modulus = n; start = 1'b1;
    sbq.push_back(ex);
    start_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    base = W'($urandom); exponent = EW'($urandom); modulus = W'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int  target;
    bit  ok;
    target = done_cnt + 1;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      if (done_cnt >= target) ok = 1'b1;
    end
    if (!ok) chk("done_wait_expired", 0, 1);
  endtask

  task automatic wait_rise(input int budget, output int rise_cyc);
    bit seen_low, ok;
    seen_low = !busy;
    ok = 1'b0;
    rise_cyc = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      if (!busy) seen_low = 1'b1;
      else if (seen_low) begin
        ok = 1'b1;
        rise_cyc = cyc;
      end
    end
    if (!ok) chk("accept_wait_expired", 0, 1);
  endtask

  task automatic run(input logic [W-1:0] b, input logic [EW-1:0] e,
                     input logic [W-1:0] n, input int lat);
    lat_mode = lat;
    issue(b, e, n, ref_op(b, e, n));
    wait_done(4000);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_mm_start"}, int'(mm_start), 0);
    chk({tag, "_mm_a"}, int'(mm_a), 0);
    chk({tag, "_mm_b"}, int'(mm_b), 0);
    chk({tag, "_mm_n"}, int'(mm_n), 0);
  endtask

  exp_t hang_exp;
  int   rise, d0;
  logic [W-1:0]  rb, rn;
  logic [EW-1:0] re;

  initial begin
    reset = 1'b1; start = 1'b0;
    base = '0; exponent = '0; modulus = '0;
    hang_exp = '0;
    hang_exp.res = W'(1); hang_exp.err = 1'b1; hang_exp.calls = 8'd1;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    #1 reset = 1'b0;

    run(6'd3, 6'd5, 6'd7, 8);
    run(6'd5, 6'd63, 6'd61, 8);
    run(6'd4, 6'd0, 6'd11, 5);
    run(6'd4, 6'd0, 6'd1, 5);
    run(6'd0, 6'd9, 6'd0, 5);
    chk("n0_done_latency", done_cyc - start_cyc, 2);

    // Multiplier never answers: abort TIMEOUT cycles after the first call.
    lat_mode = -1;
    issue(6'd3, 6'd5, 6'd7, hang_exp);
    wait_done(400);
    chk("hang_timeout_cycles", done_cyc - last_first_start, TMO);

    // Latency TIMEOUT-1 still completes; latency TIMEOUT aborts.
    run(6'd2, 6'd1, 6'd5, TMO - 1);
    lat_mode = TMO;
    issue(6'd2, 6'd1, 6'd5, hang_exp);
    wait_done(400);
    chk("edge_timeout_cycles", done_cyc - last_first_start, TMO);

    // Reset in SQ_WAIT of the third call.
    lat_mode = 8;
    issue(6'd3, 6'd5, 6'd7, ref_op(6'd3, 6'd5, 6'd7));
    for (int i = 0; i < 400 && ncalls < 3; i++) begin
      @(negedge clk); #1;
    end
    chk("reached_third_call", ncalls, 3);
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    #1 reset = 1'b0;
    void'(sbq.pop_back());
    d0 = done_cnt;
    repeat (60) @(negedge clk);
    chk("no_done_after_abort", done_cnt - d0, 0);
    run(6'd2, 6'd10, 6'd13, 8);

    // start held high across three operations.
    lat_mode = 0;
    @(negedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      rn = W'($urandom_range(2, 63));
      rb = W'($urandom_range(0, int'(rn) - 1));
      re = EW'($urandom);
      base = rb; exponent = re; modulus = rn; start = 1'b1;
      sbq.push_back(ref_op(rb, re, rn));
      wait_rise(4000, rise);
      if (k > 0) chk("held_start_restart", rise - done_cyc, 2);
    end
    start = 1'b0;
    wait_done(4000);

    // Randomized operations with random multiplier latency.
    for (int k = 0; k < 25; k++) begin
      rn = W'($urandom_range(0, 63));
      rb = (rn == '0) ? '0 : W'($urandom_range(0, int'(rn) - 1));
      re = EW'($urandom);
      run(rb, re, rn, 0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
